midi_cmd_master: RTL and testbench

- Avalon-MM master that drives the synthesizer command slave port (avs_s0_write / avs_s0_writedata) from a MIDI byte stream, for example from a UART receiver.
- Parses channel voice messages: note on, note off, and CC 123 (All Notes Off).
- Packs each message into the synthesizer's 16-bit command word and queues it in a small FIFO.
- Issues each queued command as one Avalon write, honouring waitrequest.

---
 rtl/midi_cmd_master.sv | 146 ++++++++++++++
 tb/tb_midi_cmd_master.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_cmd_master.sv
// MIDI byte stream to Avalon-MM synthesizer command master: parses note on/off and
// CC 123, queues 16-bit command words, issues one write per command. Optional MIDI_CHANNEL_FILTER_EN.
module midi_cmd_master #(
  parameter int P_FIFO_DEPTH = 4,
  parameter int P_CHANNEL    = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte_data,
  output logic        o_byte_ready,
  output logic        avm_m0_write,
  output logic [31:0] avm_m0_writedata,
  input  logic        avm_m0_waitrequest,
  output logic [15:0] o_cmd_count,
  output logic [1:0]  o_dbg_state
);

  // Handshakes: a byte transfers on a rising edge where i_byte_valid && o_byte_ready;
  // a command transfers on a rising edge where avm_m0_write && !avm_m0_waitrequest,
  // and write/writedata hold stable while waitrequest is high.

  localparam int AW = $clog2(P_FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_D1, ST_WAIT_D2, ST_SKIP} state_t;

  state_t      state;
  logic [3:0]  rs_type;
  logic [3:0]  rs_chan;
  logic [6:0]  d1;

  logic [15:0] mem [P_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  logic fifo_full, fifo_empty, accept, is_status, is_realtime, chan_ok;
  logic cmd_ok, push, pop;
  logic [15:0] cmd_word;

  assign fifo_full   = (count == (AW+1)'(P_FIFO_DEPTH));
  assign fifo_empty  = (count == '0);
  assign o_byte_ready = !fifo_full;
  assign accept      = i_byte_valid && o_byte_ready;
  assign is_status   = i_byte_data[7];
  assign is_realtime = (i_byte_data[7:3] == 5'b11111);
  assign o_dbg_state = state;

`ifdef MIDI_CHANNEL_FILTER_EN
  assign chan_ok = (rs_chan == P_CHANNEL[3:0]);
`else
  logic unused_chan;
  assign chan_ok     = 1'b1;
  assign unused_chan = ^{rs_chan, P_CHANNEL[3:0]};
`endif

  // Command built from the held running status, latched d1 and the incoming d2.
  always_comb begin
    cmd_word = 16'h0000;
    cmd_ok   = 1'b0;
    case (rs_type)
      4'h9: begin
        cmd_ok   = chan_ok;
        cmd_word = (i_byte_data[6:0] != 7'd0) ? {1'b1, d1, 1'b0, i_byte_data[6:0]}
                                              : {1'b0, d1, 8'h00};
      end
      4'h8: begin
        cmd_ok   = chan_ok;
        cmd_word = {1'b0, d1, 1'b0, i_byte_data[6:0]};
      end
      4'hB: begin
        cmd_ok   = chan_ok && (d1 == 7'd123);
        cmd_word = 16'h7F00;
      end
      default: begin
        cmd_ok   = 1'b0;
        cmd_word = 16'h0000;
      end
    endcase
  end

  assign push = accept && !is_status && (state == ST_WAIT_D2) && cmd_ok;
  assign pop  = avm_m0_write && !avm_m0_waitrequest;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      rs_type <= 4'h0;
      rs_chan <= 4'h0;
      d1      <= 7'd0;
    end else if (accept) begin
      if (is_status) begin
        if (is_realtime) begin
          state <= state;
        end else if (i_byte_data[7:4] == 4'hF) begin
          state   <= ST_IDLE;
          rs_type <= 4'h0;
        end else begin
          rs_type <= i_byte_data[7:4];
          rs_chan <= i_byte_data[3:0];
          if (i_byte_data[7:4] == 4'h8 || i_byte_data[7:4] == 4'h9 || i_byte_data[7:4] == 4'hB)
            state <= ST_WAIT_D1;
          else
            state <= ST_SKIP;
        end
      end else begin
        case (state)
          ST_WAIT_D1: begin
            d1    <= i_byte_data[6:0];
            state <= ST_WAIT_D2;
          end
          ST_WAIT_D2: state <= ST_WAIT_D1;
          default:    state <= state;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      o_cmd_count <= 16'h0000;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        o_cmd_count <= o_cmd_count + 16'h0001;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Outputs come straight from registered FIFO state so reset clears them immediately.
  assign avm_m0_write     = !fifo_empty;
  assign avm_m0_writedata = fifo_empty ? 32'h0 : {16'h0000, mem[rd_ptr]};

endmodule

// File: tb/tb_midi_cmd_master.sv
// Randomized and directed bench for midi_cmd_master against a message-level MIDI model.
module tb_midi_cmd_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_byte_valid;
  logic [7:0]  i_byte_data;
  logic        o_byte_ready;
  logic        avm_m0_write;
  logic [31:0] avm_m0_writedata;
  logic        avm_m0_waitrequest;
  logic [15:0] o_cmd_count;
  logic [1:0]  o_dbg_state;

  midi_cmd_master #(.P_FIFO_DEPTH(4), .P_CHANNEL(0)) dut (
    .clk(clk), .reset(reset),
    .i_byte_valid(i_byte_valid), .i_byte_data(i_byte_data), .o_byte_ready(o_byte_ready),
    .avm_m0_write(avm_m0_write), .avm_m0_writedata(avm_m0_writedata),
    .avm_m0_waitrequest(avm_m0_waitrequest), .o_cmd_count(o_cmd_count),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  int          model_cnt = 0;
  int          rs = -1;
  logic [7:0]  dq[$];
  logic        mon_en = 1'b0;
  logic        rand_wr = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: running status plus a list of collected data bytes.
  task automatic model_byte(input logic [7:0] b);
    int hi, ch, d1, d2;
    bit ok;
    if (b >= 8'hF8) return;
    if (b >= 8'hF0) begin rs = -1; dq.delete(); return; end
    if (b[7]) begin rs = int'(b); dq.delete(); return; end
    if (rs < 0) return;
    dq.push_back(b);
    if (dq.size() < 2) return;
    hi = rs / 16;
    ch = rs % 16;
    d1 = int'(dq[0]);
    d2 = int'(dq[1]);
    dq.delete();
`ifdef MIDI_CHANNEL_FILTER_EN
    ok = (ch == 0);
`else
    ok = 1'b1;
`endif
    if (!ok) return;
    if (hi == 9 && d2 != 0) begin exp_q.push_back(32'h8000 + d1 * 256 + d2); model_cnt++; end
    else if (hi == 9)       begin exp_q.push_back(d1 * 256); model_cnt++; end
    else if (hi == 8)       begin exp_q.push_back(d1 * 256 + d2); model_cnt++; end
    else if (hi == 11 && d1 == 123) begin exp_q.push_back(32'h7F00); model_cnt++; end
  endtask

  task automatic model_reset();
    rs = -1;
    dq.delete();
    exp_q.delete();
    model_cnt = 0;
  endtask

  // driver: inputs change on the falling edge, handshake sampled there too
  task automatic send_byte(input logic [7:0] b);
    bit hs = 1'b0;
    for (int t = 0; t < 300 && !hs; t++) begin
      @(negedge clk);
      i_byte_valid = 1'b1;
      i_byte_data  = b;
      hs = o_byte_ready;
      @(posedge clk);
      #1;
    end
    i_byte_valid = 1'b0;
    if (hs) model_byte(b);
    else check_eq("byte_timeout", 32'(o_byte_ready), 32'd1);
  endtask

  task automatic send_msg(input logic [7:0] s, input logic [7:0] a, input logic [7:0] v);
    send_byte(s);
    send_byte(a);
    send_byte(v);
  endtask

  task automatic drain(input string tag);
    bit done = 1'b0;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clk);
      #1;
      done = (exp_q.size() == 0);
    end
    if (!done) check_eq({tag, "_drain_timeout"}, exp_q.size(), 0);
    @(negedge clk);
    check_eq({tag, "_idle_write"}, 32'(avm_m0_write), 32'd0);
    check_eq({tag, "_cmd_count"}, 32'(o_cmd_count), 32'(model_cnt[15:0]));
  endtask

  // scoreboard / monitor on the falling edge
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = 32'h0;
  always @(negedge clk) begin
    if (!mon_en) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("hold_write", 32'(avm_m0_write), 32'd1);
        check_eq("hold_data", avm_m0_writedata, prev_data);
      end
      if (avm_m0_write && !avm_m0_waitrequest) begin
        if (exp_q.size() == 0) check_eq("unexpected_write", 32'(avm_m0_write), 32'd0);
        else check_eq("wdata", avm_m0_writedata, exp_q.pop_front());
      end
      prev_stall <= avm_m0_write && avm_m0_waitrequest;
      prev_data  <= avm_m0_writedata;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_wr) avm_m0_waitrequest = ($urandom_range(0, 2) == 0);
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] dir_bytes [18] = '{8'h80, 8'h40, 8'h00, 8'h90, 8'h40, 8'h00,
                                 8'h90, 8'h3C, 8'h50, 8'hF8, 8'h3E, 8'h50,
                                 8'hB0, 8'h7B, 8'h00, 8'hB0, 8'h07, 8'h40};

  initial begin
    reset = 1'b0;
    i_byte_valid = 1'b0;
    i_byte_data = 8'h00;
    avm_m0_waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_write", 32'(avm_m0_write), 32'd0);
    check_eq("rst_wdata", avm_m0_writedata, 32'h0);
    check_eq("rst_count", 32'(o_cmd_count), 32'd0);
    check_eq("rst_ready", 32'(o_byte_ready), 32'd1);
    check_eq("rst_state", 32'(o_dbg_state), 32'd0);
    reset = 1'b1;
    mon_en = 1'b1;

    // single note on with latency check
    send_msg(8'h90, 8'h40, 8'h64);
    @(negedge clk);
    check_eq("latency_write", 32'(avm_m0_write), 32'd1);
    check_eq("latency_wdata", avm_m0_writedata, 32'h0000C064);
    drain("note_on");

    // note off forms, running status with realtime, CC handling
    foreach (dir_bytes[i]) send_byte(dir_bytes[i]);
    send_msg(8'hA0, 8'h40, 8'h10);
    send_msg(8'h91, 8'h40, 8'h64);
    drain("directed");

    // stall: fill the FIFO, confirm backpressure, then release
    avm_m0_waitrequest = 1'b1;
    for (int n = 0; n < 4; n++) send_msg(8'h90, 8'(8'h30 + n), 8'h40);
    @(negedge clk);
    check_eq("ready_full", 32'(o_byte_ready), 32'd0);
    check_eq("stall_head", avm_m0_writedata, 32'h0000B040);
    fork
      send_msg(8'h90, 8'h34, 8'h40);
      begin
        repeat (20) @(posedge clk);
        #1;
        check_eq("ready_still_full", 32'(o_byte_ready), 32'd0);
        avm_m0_waitrequest = 1'b0;
      end
    join
    drain("stall");

    // reset mid-operation
    avm_m0_waitrequest = 1'b1;
    send_msg(8'h90, 8'h41, 8'h22);
    send_msg(8'h90, 8'h42, 8'h23);
    @(negedge clk);
    mon_en = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_eq("rstmid_write", 32'(avm_m0_write), 32'd0);
    check_eq("rstmid_wdata", avm_m0_writedata, 32'h0);
    check_eq("rstmid_ready", 32'(o_byte_ready), 32'd1);
    check_eq("rstmid_count", 32'(o_cmd_count), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    avm_m0_waitrequest = 1'b0;
    mon_en = 1'b1;
    send_byte(8'h40);
    send_byte(8'h64);
    repeat (8) @(negedge clk);
    check_eq("no_running_status_state", 32'(o_dbg_state), 32'd0);
    drain("after_reset");

    // randomized byte stream with random waitrequest
    rand_wr = 1'b1;
    for (int k = 0; k < 500; k++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 11);
      case (r)
        0, 1: begin
          case ($urandom_range(0, 2))
            0: b = 8'h80;
            1: b = 8'h90;
            default: b = 8'hB0;
          endcase
          b = b | 8'($urandom_range(0, 1) * $urandom_range(0, 15));
        end
        2: b = 8'(8'hA0 + 16 * $urandom_range(0, 4));
        3: b = 8'(8'hF0 + $urandom_range(0, 7));
        4: b = 8'(8'hF8 + $urandom_range(0, 7));
        5: b = ($urandom_range(0, 1) == 0) ? 8'd123 : 8'd0;
        default: b = 8'($urandom_range(0, 127));
      endcase
      send_byte(b);
    end
    rand_wr = 1'b0;
    #2;
    avm_m0_waitrequest = 1'b0;
    drain("random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
